cpu_register_bank: RTL and testbench
====================================

# cpu_register_bank

Parametrised bank of CPU working registers (AC, X, Y, S and extensions) for the cpu6502 datapath, replacing individual single-load registers with one block. Each cycle it performs at most one write operation (load from bus, increment, decrement, or register-to-register transfer) on one selected register. It offers two combinational read ports and registered zero/negative/wrap result flags to the status logic. Sits between the internal data bus, the ALU output and the P-register flag logic.

## Interface

Parameters:
- WIDTH, 8, bits per register.
- NUM_REGS, 4, number of registers; index 0=AC, 1=X, 2=Y, 3=S by convention.
- SEL_W, $clog2(NUM_REGS), width of register selects (derived, not overridden).

Ports:
- i_clk  in  1  clock; all state updates on falling edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_data  in  WIDTH  write data from data bus (LOAD op).
- i_op  in  3  operation: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 XFER; 5–7 treated as NOP.
- i_sel  in  SEL_W  destination register.
- i_rsel_a  in  SEL_W  read port A select; also XFER source.
- i_rsel_b  in  SEL_W  read port B select.
- o_data_a  out  WIDTH  contents of register i_rsel_a.
- o_data_b  out  WIDTH  contents of register i_rsel_b.
- o_zero  out  1  last written result == 0.
- o_negative  out  1  MSB of last written result.
- o_wrap  out  1  last op was INC from all-ones or DEC from zero.

## Operation

- Result computed combinationally from op: LOAD → i_data; INC → reg[i_sel]+1 mod 2^WIDTH; DEC → reg[i_sel]−1 mod 2^WIDTH; XFER → reg[i_rsel_a].
- On falling edge with valid non-NOP op: reg[i_sel] ← result; o_zero, o_negative updated from result; o_wrap set for INC at all-ones or DEC at zero, cleared for every other non-NOP op.
- NOP / ops 5–7: registers and all flags hold.
- i_sel or i_rsel_a ≥ NUM_REGS (non-power-of-two NUM_REGS): write suppressed, flags hold; out-of-range read ports return 0.
- XFER with i_rsel_a == i_sel: register unchanged, flags updated from its value (acts as flag test).
- Reads are combinational from current register state; a write becomes visible on read ports immediately after the falling edge that performs it.
- Reset (asserted at any time, including mid-cycle): all registers 0, o_zero 0, o_negative 0, o_wrap 0, immediately and independent of clock; ops ignored while i_reset_n low. Reset values are all zero; S initialisation is the sequencer's job.

## Timing

- Write latency: one falling edge; inputs sampled at falling edge of i_clk.
- Flags are registered alongside the write; valid from the same edge, held until next non-NOP op.
- Read path: zero-cycle combinational mux (plus bypass when enabled, below).
- Back-to-back ops on the same register each cycle are legal; each uses the value written at the previous edge (e.g. INC, INC → +2 after two edges).
- Reset deassertion is asynchronous-assert/synchronous-release-safe only if the top level synchronises i_reset_n; block itself makes no release guarantee.

## Configuration

- Macro CPU_REGISTER_BANK_BYPASS_EN.
- Defined: read ports forward the pending result when their select equals i_sel and op is a valid write (LOAD/INC/DEC/XFER, in range), so o_data_a/o_data_b show the new value before the edge. XFER source read on port A is never bypassed from itself (no combinational loop: when i_rsel_a == i_sel under XFER, port A shows stored value).
- Undefined: read ports show stored contents only; no forwarding logic synthesised.

## Structure

- Shared package cpu6502_pkg: op encoding constants (REG_OP_NOP, REG_OP_LOAD, REG_OP_INC, REG_OP_DEC, REG_OP_XFER) and register index constants (REG_AC, REG_X, REG_Y, REG_S).
- One sub-module natural: register_bank_alu, combinational result/wrap computation (op, operand, i_data → result, wrap). Storage, flags and read muxes stay in the top.

## Test plan

- Reset: drive i_reset_n low mid-cycle after loading AC=0x5A → all registers read 0, flags 0 immediately, without clock edge.
- LOAD X=0x80 → o_data_a (rsel X)=0x80, o_negative 1, o_zero 0, o_wrap 0 after the falling edge.
- INC S from 0xFF → S=0x00, o_zero 1, o_wrap 1; next DEC S → 0xFF, o_negative 1, o_wrap 1; NOP → all flags hold.
- XFER AC=0x00 into Y (rsel_a=AC, sel=Y) → Y=0x00, o_zero 1, AC unchanged; op 6 next cycle → nothing changes.
- NUM_REGS=5, WIDTH=16: LOAD reg 4=0x8000 then write to sel 6 → reg 4 kept, flags hold, read of index 6 returns 0.
- With CPU_REGISTER_BANK_BYPASS_EN: LOAD AC=0x33 with rsel_b=AC → o_data_b=0x33 before the edge; without macro → old value until edge.

Source files
------------

// File: rtl/cpu6502_pkg.sv
// Shared cpu6502 datapath constants: register-bank op encodings and register indices.
package cpu6502_pkg;

  localparam logic [2:0] REG_OP_NOP  = 3'd0;
  localparam logic [2:0] REG_OP_LOAD = 3'd1;
  localparam logic [2:0] REG_OP_INC  = 3'd2;
  localparam logic [2:0] REG_OP_DEC  = 3'd3;
  localparam logic [2:0] REG_OP_XFER = 3'd4;

  localparam int unsigned REG_AC = 0;
  localparam int unsigned REG_X  = 1;
  localparam int unsigned REG_Y  = 2;
  localparam int unsigned REG_S  = 3;

endpackage

// File: rtl/register_bank_alu.sv
// Combinational result/wrap computation for cpu_register_bank.
module register_bank_alu
  import cpu6502_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] result_o,
  output logic             wrap_o,
  output logic             write_op_o
);

  always_comb begin
    result_o   = '0;
    wrap_o     = 1'b0;
    write_op_o = 1'b0;
    case (op_i)
      REG_OP_LOAD: begin
        result_o   = data_i;
        write_op_o = 1'b1;
      end
      REG_OP_INC: begin
        result_o   = operand_i + WIDTH'(1);
        wrap_o     = &operand_i;
        write_op_o = 1'b1;
      end
      REG_OP_DEC: begin
        result_o   = operand_i - WIDTH'(1);
        wrap_o     = ~|operand_i;
        write_op_o = 1'b1;
      end
      REG_OP_XFER: begin
        result_o   = operand_i;
        write_op_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_register_bank.sv
// CPU working-register bank (AC/X/Y/S...) with one write op per falling edge and result flags.
// Define CPU_REGISTER_BANK_BYPASS_EN to forward the pending result onto the read ports.
module cpu_register_bank
  import cpu6502_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4,
  localparam int unsigned SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic [2:0]       i_op,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [SEL_W-1:0] i_rsel_a,
  input  logic [SEL_W-1:0] i_rsel_b,
  output logic [WIDTH-1:0] o_data_a,
  output logic [WIDTH-1:0] o_data_b,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_wrap
);

  localparam logic [SEL_W:0] NumRegsW = (SEL_W + 1)'(NUM_REGS);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic             zero_q, neg_q, wrap_q;

  logic             sel_ok, a_ok, b_ok;
  logic [WIDTH-1:0] dst_val, src_val, stored_b, operand;
  logic [WIDTH-1:0] result;
  logic             wrap, write_op, we;

  assign sel_ok = {1'b0, i_sel} < NumRegsW;
  assign a_ok   = {1'b0, i_rsel_a} < NumRegsW;
  assign b_ok   = {1'b0, i_rsel_b} < NumRegsW;

  always_comb begin
    dst_val  = sel_ok ? regs_q[i_sel] : '0;
    src_val  = a_ok ? regs_q[i_rsel_a] : '0;
    stored_b = b_ok ? regs_q[i_rsel_b] : '0;
    operand  = (i_op == REG_OP_XFER) ? src_val : dst_val;
  end

  register_bank_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op_i      (i_op),
    .operand_i (operand),
    .data_i    (i_data),
    .result_o  (result),
    .wrap_o    (wrap),
    .write_op_o(write_op)
  );

  // The XFER source must exist too, otherwise the write is dropped with flags held.
  assign we = write_op && sel_ok && ((i_op != REG_OP_XFER) || a_ok);

  always_ff @(negedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else if (we) begin
      regs_q[i_sel] <= result;
      zero_q        <= (result == '0);
      neg_q         <= result[WIDTH-1];
      wrap_q        <= wrap;
    end
  end

  always_comb begin
    o_data_a = src_val;
    o_data_b = stored_b;
`ifdef CPU_REGISTER_BANK_BYPASS_EN
    // Port A feeds XFER, so it never forwards its own XFER result.
    if (we && (i_rsel_a == i_sel) && (i_op != REG_OP_XFER)) begin
      o_data_a = result;
    end
    if (we && (i_rsel_b == i_sel)) begin
      o_data_b = result;
    end
`endif
  end

  assign o_zero     = zero_q;
  assign o_negative = neg_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_cpu_register_bank.sv
// Randomized and directed bench for cpu_register_bank against an array-based reference model.
module tb_cpu_register_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  i_data = '0;
  logic [2:0]  i_op = '0;
  logic [1:0]  i_sel = '0, i_rsel_a = '0, i_rsel_b = '0;
  logic [7:0]  o_data_a, o_data_b;
  logic        o_zero, o_negative, o_wrap;

  logic [15:0] w_data = '0;
  logic [2:0]  w_op = '0;
  logic [2:0]  w_sel = '0, w_rsel_a = '0, w_rsel_b = '0;
  logic [15:0] w_data_a, w_data_b;
  logic        w_zero, w_negative, w_wrap;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_regs [4];
  logic       m_zero, m_neg, m_wrap;

  always #5 clk = ~clk;

  cpu_register_bank u_dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_data    (i_data),
    .i_op      (i_op),
    .i_sel     (i_sel),
    .i_rsel_a  (i_rsel_a),
    .i_rsel_b  (i_rsel_b),
    .o_data_a  (o_data_a),
    .o_data_b  (o_data_b),
    .o_zero    (o_zero),
    .o_negative(o_negative),
    .o_wrap    (o_wrap)
  );

  cpu_register_bank #(
    .WIDTH   (16),
    .NUM_REGS(5)
  ) u_dut5 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_data    (w_data),
    .i_op      (w_op),
    .i_sel     (w_sel),
    .i_rsel_a  (w_rsel_a),
    .i_rsel_b  (w_rsel_b),
    .o_data_a  (w_data_a),
    .o_data_b  (w_data_b),
    .o_zero    (w_zero),
    .o_negative(w_negative),
    .o_wrap    (w_wrap)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_zero = 1'b0;
    m_neg  = 1'b0;
    m_wrap = 1'b0;
  endtask

  // One op on the 4x8 bank: drive after the rising edge, check before and after the falling edge.
  task automatic step(input logic [2:0] op, input logic [1:0] sel, input logic [1:0] ra,
                      input logic [1:0] rb, input logic [7:0] data);
    int   res;
    logic wr, wrp;
    logic [7:0] pre_b;
    @(posedge clk);
    i_op = op; i_sel = sel; i_rsel_a = ra; i_rsel_b = rb; i_data = data;
    #1;
    wr  = (op >= 3'd1) && (op <= 3'd4);
    res = 0;
    wrp = 1'b0;
    case (op)
      3'd1: res = int'(data);
      3'd2: begin res = (int'(m_regs[sel]) + 1) % 256; wrp = (m_regs[sel] == 8'd255); end
      3'd3: begin res = (int'(m_regs[sel]) + 255) % 256; wrp = (m_regs[sel] == 8'd0); end
      3'd4: res = int'(m_regs[ra]);
      default: ;
    endcase
    pre_b = m_regs[rb];
`ifdef CPU_REGISTER_BANK_BYPASS_EN
    if (wr && (rb == sel)) pre_b = res[7:0];
`endif
    check_eq("pre_edge_b", {24'd0, o_data_b}, {24'd0, pre_b});
    @(negedge clk);
    #1;
    if (wr) begin
      m_regs[sel] = res[7:0];
      m_zero = (res == 0);
      m_neg  = (res >= 128);
      m_wrap = wrp;
    end
    check_eq("data_a", {24'd0, o_data_a}, {24'd0, m_regs[ra]});
    check_eq("data_b", {24'd0, o_data_b}, {24'd0, m_regs[rb]});
    check_eq("zero", {31'd0, o_zero}, {31'd0, m_zero});
    check_eq("negative", {31'd0, o_negative}, {31'd0, m_neg});
    check_eq("wrap", {31'd0, o_wrap}, {31'd0, m_wrap});
  endtask

  task automatic step5(input logic [2:0] op, input logic [2:0] sel, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [15:0] data);
    @(posedge clk);
    w_op = op; w_sel = sel; w_rsel_a = ra; w_rsel_b = rb; w_data = data;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    model_reset();
    #2;
    check_eq("rst_data_a", {24'd0, o_data_a}, 32'd0);
    check_eq("rst_flags", {29'd0, o_zero, o_negative, o_wrap}, 32'd0);
    @(posedge clk);
    rst_n = 1'b1;

    // LOAD X=0x80
    step(3'd1, 2'd1, 2'd1, 2'd0, 8'h80);
    check_eq("ldx_val", {24'd0, o_data_a}, 32'h80);
    check_eq("ldx_flags", {29'd0, o_zero, o_negative, o_wrap}, 32'b010);

    // INC S from 0xFF, DEC back, NOP holds
    step(3'd1, 2'd3, 2'd3, 2'd3, 8'hFF);
    step(3'd2, 2'd3, 2'd3, 2'd1, 8'h00);
    check_eq("incs_val", {24'd0, o_data_a}, 32'h00);
    check_eq("incs_flags", {29'd0, o_zero, o_negative, o_wrap}, 32'b101);
    step(3'd3, 2'd3, 2'd3, 2'd1, 8'h00);
    check_eq("decs_val", {24'd0, o_data_a}, 32'hFF);
    check_eq("decs_flags", {29'd0, o_zero, o_negative, o_wrap}, 32'b011);
    step(3'd0, 2'd3, 2'd3, 2'd1, 8'h12);
    check_eq("nop_flags", {29'd0, o_zero, o_negative, o_wrap}, 32'b011);

    // XFER AC=0 into Y, then op 6 changes nothing
    step(3'd1, 2'd0, 2'd0, 2'd0, 8'h00);
    step(3'd1, 2'd2, 2'd0, 2'd2, 8'h44);
    step(3'd4, 2'd2, 2'd0, 2'd2, 8'hAA);
    check_eq("xfer_y", {24'd0, o_data_b}, 32'h00);
    check_eq("xfer_zero", {31'd0, o_zero}, 32'd1);
    step(3'd6, 2'd2, 2'd0, 2'd2, 8'h55);
    check_eq("op6_y", {24'd0, o_data_b}, 32'h00);

    // XFER onto itself is a flag test
    step(3'd4, 2'd1, 2'd1, 2'd1, 8'h00);
    check_eq("xself_flags", {29'd0, o_zero, o_negative, o_wrap}, 32'b010);

    // Randomized ops biased toward wrap-prone values
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0: d = 8'h00;
        1: d = 8'hFF;
        2: d = 8'h80;
        default: d = 8'($urandom);
      endcase
      step(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 2'($urandom), d);
    end

    // Mid-cycle asynchronous reset after loading AC
    step(3'd1, 2'd0, 2'd0, 2'd0, 8'h5A);
    @(posedge clk);
    i_op = 3'd1; i_sel = 2'd0; i_rsel_a = 2'd0; i_data = 8'h11;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ac", {24'd0, o_data_a}, 32'd0);
    check_eq("arst_flags", {29'd0, o_zero, o_negative, o_wrap}, 32'd0);
    @(negedge clk);
    #1;
    check_eq("arst_hold", {24'd0, o_data_a}, 32'd0);
    model_reset();
    @(posedge clk);
    i_op = 3'd0;
    rst_n = 1'b1;

    // 5x16 bank: out-of-range writes and reads
    step5(3'd1, 3'd4, 3'd4, 3'd4, 16'h8000);
    check_eq("r5_load", {16'd0, w_data_a}, 32'h8000);
    check_eq("r5_flags", {29'd0, w_zero, w_negative, w_wrap}, 32'b010);
    step5(3'd1, 3'd6, 3'd4, 3'd6, 16'h0000);
    check_eq("r5_kept", {16'd0, w_data_a}, 32'h8000);
    check_eq("r5_oob_rd", {16'd0, w_data_b}, 32'h0000);
    check_eq("r5_hold", {29'd0, w_zero, w_negative, w_wrap}, 32'b010);
    step5(3'd4, 3'd4, 3'd7, 3'd4, 16'h0000);
    check_eq("r5_xfer_oob", {16'd0, w_data_b}, 32'h8000);
    check_eq("r5_xfer_hold", {29'd0, w_zero, w_negative, w_wrap}, 32'b010);
    step5(3'd3, 3'd0, 3'd0, 3'd4, 16'h0000);
    check_eq("r5_dec0", {16'd0, w_data_a}, 32'hFFFF);
    check_eq("r5_dec_flags", {29'd0, w_zero, w_negative, w_wrap}, 32'b011);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
